// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator/checker pair.
// Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form.
package lfsr_pkg;

  // Taps on bits 7,5,4,3 feed the new LSB.
  localparam logic [7:0] TAP_MASK = 8'hB8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & TAP_MASK)};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between the checker and its surroundings.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             din_vld;
  logic [7:0]       din;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             lockup;

  modport master (
    output din_vld, din, clr_cnt,
    input  locked, err, err_cnt, lockup
  );

  modport slave (
    input  din_vld, din, clr_cnt,
    output locked, err, err_cnt, lockup
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream: lock, per-word error, saturating count.
// Optional LFSR_CHK_LOCKUP_EN: flag all-zero words (sticky lockup) and never accept them as matches.
//
//   state  | meaning
//   SEARCH | hunting for LOCK_CNT consecutive correct predictions, no error reporting
//   LOCKED | checking every valid word, flywheel prediction across corrupted words
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  lfsr_checker_if.slave   chk
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_TC   = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_TC = UW'(UNLOCK_CNT);

  chk_state_t       state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [UW-1:0]    miss_q, miss_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]    pred;
  logic          is_match;
  logic [MW-1:0] match_inc;
  logic [UW-1:0] miss_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      prev_q      <= 8'h00;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    pred        = lfsr_next(prev_q);
    match_inc   = match_q + 1'b1;
    miss_inc    = miss_q + 1'b1;
`ifdef LFSR_CHK_LOCKUP_EN
    is_match    = (chk.din == pred) && (chk.din != 8'h00);
`else
    is_match    = (chk.din == pred);
`endif

    if (chk.din_vld) begin
      unique case (state_q)
        SEARCH: begin
          prev_d      = chk.din;
          have_prev_d = 1'b1;
          if (have_prev_q) begin
            if (is_match) begin
              match_d = match_inc;
              if (match_inc == LOCK_TC) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (is_match) begin
            miss_d = '0;
            prev_d = chk.din;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // Flywheel on the prediction unless this miss drops lock.
            if (miss_inc == UNLOCK_TC) begin
              state_d     = SEARCH;
              match_d     = '0;
              prev_d      = chk.din;
              have_prev_d = 1'b1;
            end else begin
              prev_d = pred;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (chk.clr_cnt) cnt_d = '0;
  end

`ifdef LFSR_CHK_LOCKUP_EN
  logic lockup_q, lockup_d;

  always_comb begin
    lockup_d = lockup_q;
    if (chk.din_vld && (chk.din == 8'h00)) lockup_d = 1'b1;
    if (chk.clr_cnt) lockup_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lockup_q <= 1'b0;
    else        lockup_q <= lockup_d;
  end

  assign chk.lockup = lockup_q;
`else
  assign chk.lockup = 1'b0;
`endif

  assign chk.locked  = (state_q == LOCKED);
  assign chk.err     = err_q;
  assign chk.err_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: fixed vector table, hand corner sequences, randomized run vs reference model.
module tb_lfsr_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

`ifdef LFSR_CHK_LOCKUP_EN
  localparam bit LOCKUP_EN = 1'b1;
`else
  localparam bit LOCKUP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(CNT_W)) chk ();

  lfsr_checker #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .chk  (chk)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in terms of the behavioural rules only.
  int m_prev;
  bit m_have;
  int m_match;
  int m_miss;
  bit m_locked;
  bit m_err;
  int m_cnt;
  bit m_lockup;

  function automatic int nxt(input int q);
    int fb;
    fb = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
    return ((q << 1) | fb) & 255;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_have = 0; m_match = 0; m_miss = 0;
    m_locked = 0; m_err = 0; m_cnt = 0; m_lockup = 0;
  endtask

  task automatic model_step(input bit vld, input int d, input bit clr);
    bit hit;
    m_err = 0;
    if (vld) begin
      hit = (d == nxt(m_prev)) && !(LOCKUP_EN && d == 0);
      if (LOCKUP_EN && d == 0) m_lockup = 1;
      if (!m_locked) begin
        if (m_have) begin
          if (hit) begin
            m_match++;
            if (m_match >= LOCK_CNT) begin m_locked = 1; m_miss = 0; end
          end else m_match = 0;
        end
        m_prev = d;
        m_have = 1;
      end else if (hit) begin
        m_miss = 0;
        m_prev = d;
      end else begin
        m_err = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        m_miss++;
        if (m_miss >= UNLOCK_CNT) begin
          m_locked = 0; m_match = 0; m_prev = d; m_have = 1;
        end else m_prev = nxt(m_prev);
      end
    end
    if (clr) begin m_cnt = 0; m_lockup = 0; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit vld, input int d, input bit clr);
    chk.din_vld = vld;
    chk.din     = d[7:0];
    chk.clr_cnt = clr;
    model_step(vld, d, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"},  int'(chk.locked),  int'(m_locked));
    check({tag, ".err"},     int'(chk.err),     int'(m_err));
    check({tag, ".err_cnt"}, int'(chk.err_cnt), m_cnt);
    check({tag, ".lockup"},  int'(chk.lockup),  int'(m_lockup));
  endtask

  task automatic do_reset();
    chk.din_vld = 1'b0;
    chk.din     = 8'h00;
    chk.clr_cnt = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic feed_lock(input int seed, output int last);
    int w;
    w = seed;
    for (int i = 0; i < LOCK_CNT + 1; i++) begin
      step(1, w, 0);
      last = w;
      w = nxt(w);
    end
  endtask

  typedef struct {
    bit vld;
    int din;
    bit clr;
    bit e_locked;
    bit e_err;
    int e_cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int last, w, pred, k, g, d;
    bit vld, clr;

    vecs[0]  = '{1, 'h88, 0, 0, 0, 0};
    vecs[1]  = '{1, 'h10, 0, 0, 0, 0};
    vecs[2]  = '{1, 'h21, 0, 0, 0, 0};
    vecs[3]  = '{1, 'h43, 0, 0, 0, 0};
    vecs[4]  = '{1, 'h86, 0, 1, 0, 0};
    vecs[5]  = '{1, 'h0D, 0, 1, 0, 0};
    vecs[6]  = '{1, 'h1B, 0, 1, 0, 0};
    vecs[7]  = '{0, 'h55, 0, 1, 0, 0};
    vecs[8]  = '{1, 'h37, 0, 1, 1, 1};
    vecs[9]  = '{1, 'h6C, 0, 1, 0, 1};
    vecs[10] = '{1, 'h01, 0, 1, 1, 2};
    vecs[11] = '{1, 'h02, 0, 1, 1, 3};
    vecs[12] = '{1, 'h03, 0, 0, 1, 4};
    vecs[13] = '{1, 'h12, 0, 0, 0, 4};
    vecs[14] = '{1, 'h25, 0, 0, 0, 4};
    vecs[15] = '{1, 'h4B, 0, 0, 0, 4};
    vecs[16] = '{1, 'h97, 0, 0, 0, 4};
    vecs[17] = '{1, 'h2E, 0, 1, 0, 4};

    rst_n = 1'b0;
    do_reset();
    check("reset.locked",  int'(chk.locked),  0);
    check("reset.err",     int'(chk.err),     0);
    check("reset.err_cnt", int'(chk.err_cnt), 0);
    check("reset.lockup",  int'(chk.lockup),  0);

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].din, vecs[i].clr);
      check($sformatf("vec%0d.locked", i),  int'(chk.locked),  int'(vecs[i].e_locked));
      check($sformatf("vec%0d.err", i),     int'(chk.err),     int'(vecs[i].e_err));
      check($sformatf("vec%0d.err_cnt", i), int'(chk.err_cnt), vecs[i].e_cnt);
      check($sformatf("vec%0d.lockup", i),  int'(chk.lockup),  0);
    end

    // Seed 0xFF with idle cycles interleaved.
    do_reset();
    w = 'hFF;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, w, 0);
      k++;
      w = nxt(w);
      check($sformatf("gap%0d.locked", i), int'(chk.locked), int'(k >= LOCK_CNT + 1));
      check($sformatf("gap%0d.err", i), int'(chk.err), 0);
      step(0, 'hAA, 0);
      check($sformatf("gap%0d.idle_locked", i), int'(chk.locked), int'(k >= LOCK_CNT + 1));
      check($sformatf("gap%0d.idle_err", i), int'(chk.err), 0);
    end

    // Constant all-zero stream.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0);
      check($sformatf("zero%0d.locked", i), int'(chk.locked),
            LOCKUP_EN ? 0 : int'(i >= LOCK_CNT + 1));
      check($sformatf("zero%0d.lockup", i), int'(chk.lockup), int'(LOCKUP_EN));
      check($sformatf("zero%0d.err", i), int'(chk.err), 0);
    end

    // Saturation of err_cnt, flywheel across isolated errors.
    do_reset();
    feed_lock('h88, last);
    w = last;
    for (int i = 0; i < 20; i++) begin
      pred = nxt(w);
      step(1, pred ^ 'hFF, 0);
      check($sformatf("sat%0d.err", i), int'(chk.err), 1);
      check($sformatf("sat%0d.err_cnt", i), int'(chk.err_cnt), (i + 1 < CNT_MAX) ? i + 1 : CNT_MAX);
      w = pred;
      pred = nxt(w);
      step(1, pred, 0);
      check($sformatf("sat%0d.good_err", i), int'(chk.err), 0);
      check($sformatf("sat%0d.locked", i), int'(chk.locked), 1);
      w = pred;
    end

    // Clear colliding with an error: pulse still seen, count cleared.
    pred = nxt(w);
    step(1, pred ^ 'h5A, 1);
    check("clr_err.err", int'(chk.err), 1);
    check("clr_err.err_cnt", int'(chk.err_cnt), 0);
    check("clr_err.locked", int'(chk.locked), 1);
    w = pred;

    // Reset while locked.
    chk.din_vld = 1'b1;
    chk.din     = 8'(nxt(w));
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.locked",  int'(chk.locked),  0);
    check("midrst.err",     int'(chk.err),     0);
    check("midrst.err_cnt", int'(chk.err_cnt), 0);
    check("midrst.lockup",  int'(chk.lockup),  0);
    rst_n = 1'b1;
    model_reset();

    // Randomized stream with corruption, reseeds, zero words, gaps and clears.
    do_reset();
    g = $urandom_range(1, 255);
    for (int i = 0; i < 4000; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      d   = $urandom_range(0, 255);
      if (vld) begin
        if ($urandom_range(0, 63) == 0) g = $urandom_range(1, 255);
        g = nxt(g);
        d = g;
        if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 255);
        if ($urandom_range(0, 127) == 0) d = 0;
      end
      step(vld, d, clr);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
